// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/writeback/kill/redirect bundle between the pipeline and the hazard controller.
// master drives the pipeline events, slave is the controller.
interface pipe_hazard_ctrl_if;
  logic        dec_valid;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        dec_rs1_read;
  logic        dec_rs2_read;
  logic [4:0]  dec_rd;
  logic        dec_rd_write;
  logic [4:0]  wb_rd;
  logic        wb_rd_write;
  logic [4:0]  kill_rd;
  logic        kill_rd_write;
  logic        redirect;
  logic        issue_out;
  logic        stall_out;
  logic        flush_out;
  logic [1:0]  state_out;
  logic [31:0] busy_out;
  logic        err_out;

  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_rs1_read, dec_rs2_read,
    output dec_rd, dec_rd_write, wb_rd, wb_rd_write, kill_rd, kill_rd_write, redirect,
    input  issue_out, stall_out, flush_out, state_out, busy_out, err_out
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_rs1_read, dec_rs2_read,
    input  dec_rd, dec_rd_write, wb_rd, wb_rd_write, kill_rd, kill_rd_write, redirect,
    output issue_out, stall_out, flush_out, state_out, busy_out, err_out
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based interlock: per-register pending-write counters drive RAW/WAW stalls,
// and a RUN/STALL/FLUSH FSM squashes the front end for a fixed window after a redirect.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 2
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hif
);
  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX_V = '1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t     state_reg;
  logic [2:0] fcnt_reg;
  logic       flush_reg;
  logic       err_reg;

  wire [CNT_W-1:0] cnt_view [32];
  wire [31:0]      busy_vec;
  wire [31:0]      over_vec;
  wire [31:0]      under_vec;

  logic hazard_next;
  logic issue_next;
  logic stall_next;

  assign cnt_view[0]  = '0;
  assign busy_vec[0]  = 1'b0;
  assign over_vec[0]  = 1'b0;
  assign under_vec[0] = 1'b0;

  // Hazard looks only at registered counters, so a same-cycle writeback cannot release a reader.
  always_comb begin
    hazard_next = 1'b0;
    if (hif.dec_rs1_read && hif.dec_rs1 != 5'd0 && cnt_view[hif.dec_rs1] != '0)
      hazard_next = 1'b1;
    if (hif.dec_rs2_read && hif.dec_rs2 != 5'd0 && cnt_view[hif.dec_rs2] != '0)
      hazard_next = 1'b1;
    if (hif.dec_rd_write && hif.dec_rd != 5'd0 && cnt_view[hif.dec_rd] == CNT_MAX_V)
      hazard_next = 1'b1;
    hazard_next = hazard_next && hif.dec_valid;
    issue_next  = hif.dec_valid && !hazard_next && !hif.redirect && (state_reg != ST_FLUSH);
    stall_next  = hif.dec_valid &&  hazard_next && !hif.redirect && (state_reg != ST_FLUSH);
  end

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
      logic [CNT_W-1:0] c_reg;
      logic [SUM_W-1:0] sum_next;
      logic             inc_next;
      logic             wb_next;
      logic             kill_next;

      always_comb begin
        inc_next  = issue_next && hif.dec_rd_write && (hif.dec_rd == 5'(gi));
        wb_next   = hif.wb_rd_write && (hif.wb_rd == 5'(gi));
        kill_next = hif.kill_rd_write && (hif.kill_rd == 5'(gi));
        sum_next  = SUM_W'(c_reg) + SUM_W'(inc_next) - SUM_W'(wb_next) - SUM_W'(kill_next);
      end

      // Top bit set means the net result went negative; 2'b01 on top means it exceeded CNT_MAX.
      assign under_vec[gi] = sum_next[SUM_W-1];
      assign over_vec[gi]  = (sum_next[SUM_W-1:CNT_W] == 2'b01);

      always_ff @(posedge clk) begin
        if (rst)
          c_reg <= '0;
        else if (under_vec[gi])
          c_reg <= '0;
        else if (over_vec[gi])
          c_reg <= CNT_MAX_V;
        else
          c_reg <= sum_next[CNT_W-1:0];
      end

      assign cnt_view[gi] = c_reg;
      assign busy_vec[gi] = (c_reg != '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      fcnt_reg  <= 3'd0;
      flush_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= err_reg || (|over_vec) || (|under_vec);
      if (hif.redirect) begin
        state_reg <= ST_FLUSH;
        fcnt_reg  <= 3'(FLUSH_CYCLES);
        flush_reg <= 1'b1;
      end else begin
        case (state_reg)
          ST_FLUSH: begin
            if (fcnt_reg <= 3'd1) begin
              state_reg <= ST_RUN;
              fcnt_reg  <= 3'd0;
              flush_reg <= 1'b0;
            end else begin
              fcnt_reg  <= fcnt_reg - 3'd1;
              flush_reg <= 1'b1;
            end
          end
          default: begin
            state_reg <= (hif.dec_valid && hazard_next) ? ST_STALL : ST_RUN;
            flush_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hif.issue_out = issue_next;
  assign hif.stall_out = stall_next;
  assign hif.flush_out = flush_reg;
  assign hif.state_out = state_reg;
  assign hif.busy_out  = busy_vec;
  assign hif.err_out   = err_reg;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios plus a randomized run against an arithmetic scoreboard of
// pending writes per register and a flush-window countdown.
module tb_pipe_hazard_ctrl;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 2;
  localparam int CNT_MAX      = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hif();

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .hif(hif)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: outstanding writes per register, mode (0 run, 1 stall, 2 flush), flush cycles left.
  int m_cnt [32];
  int m_state = 0;
  int m_fl    = 0;
  bit m_err   = 1'b0;

  function automatic bit m_hazard();
    bit h;
    h = 1'b0;
    if (hif.dec_rs1_read && hif.dec_rs1 != 0 && m_cnt[hif.dec_rs1] > 0) h = 1'b1;
    if (hif.dec_rs2_read && hif.dec_rs2 != 0 && m_cnt[hif.dec_rs2] > 0) h = 1'b1;
    if (hif.dec_rd_write && hif.dec_rd != 0 && m_cnt[hif.dec_rd] >= CNT_MAX) h = 1'b1;
    return hif.dec_valid && h;
  endfunction

  function automatic bit m_issue();
    return hif.dec_valid && !m_hazard() && !hif.redirect && m_state != 2;
  endfunction

  function automatic bit m_stall();
    return hif.dec_valid && m_hazard() && !hif.redirect && m_state != 2;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] > 0);
    return b;
  endfunction

  task automatic clear_inputs();
    hif.dec_valid = 0; hif.dec_rs1 = 0; hif.dec_rs2 = 0;
    hif.dec_rs1_read = 0; hif.dec_rs2_read = 0;
    hif.dec_rd = 0; hif.dec_rd_write = 0;
    hif.wb_rd = 0; hif.wb_rd_write = 0;
    hif.kill_rd = 0; hif.kill_rd_write = 0;
    hif.redirect = 0;
  endtask

  task automatic settle();
    #1;
  endtask

  // Computes the model's next state from the inputs held now, then clocks the DUT.
  task automatic advance();
    int nc [32];
    int ns, nf, v;
    bit ne, iss;
    iss = m_issue();
    ne = m_err;
    for (int r = 0; r < 32; r++) nc[r] = 0;
    for (int r = 1; r < 32; r++) begin
      v = m_cnt[r];
      if (iss && hif.dec_rd_write && hif.dec_rd == r) v = v + 1;
      if (hif.wb_rd_write && hif.wb_rd == r) v = v - 1;
      if (hif.kill_rd_write && hif.kill_rd == r) v = v - 1;
      if (v < 0) begin v = 0; ne = 1'b1; end
      if (v > CNT_MAX) begin v = CNT_MAX; ne = 1'b1; end
      nc[r] = v;
    end
    if (hif.redirect) begin
      ns = 2; nf = FLUSH_CYCLES;
    end else if (m_state == 2) begin
      nf = m_fl - 1;
      ns = (nf == 0) ? 0 : 2;
    end else begin
      nf = 0;
      ns = (hif.dec_valid && m_hazard()) ? 1 : 0;
    end
    if (rst) begin
      for (int r = 0; r < 32; r++) nc[r] = 0;
      ns = 0; nf = 0; ne = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < 32; r++) m_cnt[r] = nc[r];
    m_state = ns; m_fl = nf; m_err = ne;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hif.dec_valid = 1; hif.dec_rd = 5'd6; hif.dec_rd_write = 1; hif.redirect = 1;
    hif.kill_rd = 5'd3; hif.kill_rd_write = 1;
    advance();
    advance();
    rst = 1'b0;
    clear_inputs();
    settle();
    n_total++; if (hif.state_out !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", hif.state_out); end
    n_total++; if (hif.flush_out !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %b want 0", hif.flush_out); end
    n_total++; if (hif.busy_out !== 32'd0) begin n_bad++; $display("FAIL reset_busy: got %h want 0", hif.busy_out); end
    n_total++; if (hif.err_out !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", hif.err_out); end
    hif.dec_valid = 1;
    settle();
    n_total++; if (hif.issue_out !== 1'b1) begin n_bad++; $display("FAIL reset_issue: got %b want 1", hif.issue_out); end
    n_total++; if (hif.stall_out !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", hif.stall_out); end
    clear_inputs();
    $display("test_reset done");
  endtask

  task automatic test_raw();
    do_reset();
    hif.dec_valid = 1; hif.dec_rd = 5'd5; hif.dec_rd_write = 1;
    settle();
    n_total++; if (hif.issue_out !== 1'b1) begin n_bad++; $display("FAIL raw_writer_issue: got %b want 1", hif.issue_out); end
    advance();
    clear_inputs();
    hif.dec_valid = 1; hif.dec_rs1 = 5'd5; hif.dec_rs1_read = 1;
    settle();
    n_total++; if (hif.busy_out[5] !== 1'b1) begin n_bad++; $display("FAIL raw_busy_set: got %b want 1", hif.busy_out[5]); end
    n_total++; if (hif.stall_out !== 1'b1 || hif.issue_out !== 1'b0) begin n_bad++; $display("FAIL raw_stall: got stall=%b issue=%b want 1/0", hif.stall_out, hif.issue_out); end
    advance(); advance();
    n_total++; if (hif.state_out !== 2'd1) begin n_bad++; $display("FAIL raw_state_stall: got %0d want 1", hif.state_out); end
    hif.wb_rd = 5'd5; hif.wb_rd_write = 1;
    settle();
    n_total++; if (hif.stall_out !== 1'b1) begin n_bad++; $display("FAIL raw_wb_same_cycle: got stall=%b want 1", hif.stall_out); end
    advance();
    hif.wb_rd_write = 0;
    settle();
    n_total++; if (hif.issue_out !== 1'b1) begin n_bad++; $display("FAIL raw_release: got issue=%b want 1", hif.issue_out); end
    n_total++; if (hif.busy_out[5] !== 1'b0) begin n_bad++; $display("FAIL raw_busy_clear: got %b want 0", hif.busy_out[5]); end
    advance();
    clear_inputs();
    settle();
    n_total++; if (hif.state_out !== 2'd0) begin n_bad++; $display("FAIL raw_back_to_run: got %0d want 0", hif.state_out); end
    $display("test_raw done");
  endtask

  task automatic test_x0();
    do_reset();
    hif.dec_valid = 1; hif.dec_rd = 5'd0; hif.dec_rd_write = 1;
    advance();
    clear_inputs();
    hif.dec_valid = 1; hif.dec_rs1 = 5'd0; hif.dec_rs1_read = 1;
    settle();
    n_total++; if (hif.stall_out !== 1'b0 || hif.issue_out !== 1'b1) begin n_bad++; $display("FAIL x0_no_stall: got stall=%b issue=%b want 0/1", hif.stall_out, hif.issue_out); end
    n_total++; if (hif.busy_out !== 32'd0) begin n_bad++; $display("FAIL x0_busy: got %h want 0", hif.busy_out); end
    advance();
    clear_inputs();
    $display("test_x0 done");
  endtask

  task automatic test_redirect();
    do_reset();
    hif.dec_valid = 1; hif.dec_rd = 5'd3; hif.dec_rd_write = 1;
    advance();
    clear_inputs();
    hif.dec_valid = 1; hif.dec_rs2 = 5'd3; hif.dec_rs2_read = 1; hif.dec_rd = 5'd12; hif.dec_rd_write = 1;
    advance();
    n_total++; if (hif.state_out !== 2'd1) begin n_bad++; $display("FAIL redir_pre_stall: got %0d want 1", hif.state_out); end
    hif.redirect = 1;
    settle();
    n_total++; if (hif.issue_out !== 1'b0 || hif.stall_out !== 1'b0) begin n_bad++; $display("FAIL redir_priority: got issue=%b stall=%b want 0/0", hif.issue_out, hif.stall_out); end
    advance();
    hif.redirect = 0;
    for (int c = 0; c < FLUSH_CYCLES; c++) begin
      settle();
      n_total++; if (hif.state_out !== 2'd2 || hif.flush_out !== 1'b1 || hif.issue_out !== 1'b0) begin n_bad++; $display("FAIL redir_flush_c%0d: got state=%0d flush=%b issue=%b want 2/1/0", c, hif.state_out, hif.flush_out, hif.issue_out); end
      advance();
    end
    n_total++; if (hif.state_out !== 2'd0 || hif.flush_out !== 1'b0) begin n_bad++; $display("FAIL redir_end: got state=%0d flush=%b want 0/0", hif.state_out, hif.flush_out); end
    n_total++; if (hif.busy_out[12] !== 1'b0) begin n_bad++; $display("FAIL redir_rd_not_counted: got %b want 0", hif.busy_out[12]); end
    clear_inputs();
    $display("test_redirect done");
  endtask

  task automatic test_waw();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      hif.dec_valid = 1; hif.dec_rd = 5'd7; hif.dec_rd_write = 1;
      settle();
      n_total++; if (hif.issue_out !== 1'b1) begin n_bad++; $display("FAIL waw_issue%0d: got %b want 1", k, hif.issue_out); end
      advance();
    end
    settle();
    n_total++; if (hif.stall_out !== 1'b1 || hif.issue_out !== 1'b0) begin n_bad++; $display("FAIL waw_fourth_stall: got stall=%b issue=%b want 1/0", hif.stall_out, hif.issue_out); end
    advance();
    hif.wb_rd = 5'd7; hif.wb_rd_write = 1;
    advance();
    hif.wb_rd_write = 0;
    settle();
    n_total++; if (hif.issue_out !== 1'b1) begin n_bad++; $display("FAIL waw_release: got %b want 1", hif.issue_out); end
    advance();
    clear_inputs();
    settle();
    n_total++; if (hif.err_out !== 1'b0) begin n_bad++; $display("FAIL waw_err: got %b want 0", hif.err_out); end
    $display("test_waw done");
  endtask

  task automatic test_simul_kill();
    do_reset();
    hif.dec_valid = 1; hif.dec_rd = 5'd9; hif.dec_rd_write = 1;
    advance();
    hif.wb_rd = 5'd9; hif.wb_rd_write = 1;
    advance();
    clear_inputs();
    settle();
    n_total++; if (hif.busy_out[9] !== 1'b1) begin n_bad++; $display("FAIL simul_net_zero: got %b want 1", hif.busy_out[9]); end
    hif.kill_rd = 5'd9; hif.kill_rd_write = 1;
    advance();
    settle();
    n_total++; if (hif.busy_out[9] !== 1'b0 || hif.err_out !== 1'b0) begin n_bad++; $display("FAIL simul_kill: got busy=%b err=%b want 0/0", hif.busy_out[9], hif.err_out); end
    advance();
    clear_inputs();
    settle();
    n_total++; if (hif.err_out !== 1'b1) begin n_bad++; $display("FAIL simul_underflow: got %b want 1", hif.err_out); end
    advance(); advance();
    n_total++; if (hif.err_out !== 1'b1) begin n_bad++; $display("FAIL simul_sticky: got %b want 1", hif.err_out); end
    $display("test_simul_kill done");
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    hif.dec_valid = 1; hif.dec_rd = 5'd4; hif.dec_rd_write = 1;
    advance();
    clear_inputs();
    hif.kill_rd = 5'd20; hif.kill_rd_write = 1;
    hif.redirect = 1;
    advance();
    clear_inputs();
    settle();
    n_total++; if (hif.state_out !== 2'd2 || hif.err_out !== 1'b1) begin n_bad++; $display("FAIL midflush_pre: got state=%0d err=%b want 2/1", hif.state_out, hif.err_out); end
    rst = 1'b1; hif.redirect = 1;
    advance();
    rst = 1'b0;
    clear_inputs();
    settle();
    n_total++; if (hif.state_out !== 2'd0 || hif.flush_out !== 1'b0) begin n_bad++; $display("FAIL midflush_state: got state=%0d flush=%b want 0/0", hif.state_out, hif.flush_out); end
    n_total++; if (hif.busy_out !== 32'd0 || hif.err_out !== 1'b0) begin n_bad++; $display("FAIL midflush_clear: got busy=%h err=%b want 0/0", hif.busy_out, hif.err_out); end
    $display("test_reset_mid_flush done");
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 300; t++) begin
      rst = ($urandom_range(0, 59) == 0);
      hif.dec_valid     = ($urandom_range(0, 3) != 0);
      hif.dec_rs1       = 5'($urandom_range(0, 7));
      hif.dec_rs2       = 5'($urandom_range(0, 7));
      hif.dec_rs1_read  = 1'($urandom_range(0, 1));
      hif.dec_rs2_read  = 1'($urandom_range(0, 1));
      hif.dec_rd        = 5'($urandom_range(0, 7));
      hif.dec_rd_write  = 1'($urandom_range(0, 1));
      hif.wb_rd         = 5'($urandom_range(0, 7));
      hif.wb_rd_write   = ($urandom_range(0, 2) != 0);
      hif.kill_rd       = 5'($urandom_range(0, 7));
      hif.kill_rd_write = ($urandom_range(0, 11) == 0);
      hif.redirect      = ($urandom_range(0, 15) == 0);
      settle();
      n_total++; if (hif.issue_out !== m_issue()) begin n_bad++; $display("FAIL rnd_issue t=%0d: got %b want %b", t, hif.issue_out, m_issue()); end
      n_total++; if (hif.stall_out !== m_stall()) begin n_bad++; $display("FAIL rnd_stall t=%0d: got %b want %b", t, hif.stall_out, m_stall()); end
      n_total++; if (hif.state_out !== 2'(m_state)) begin n_bad++; $display("FAIL rnd_state t=%0d: got %0d want %0d", t, hif.state_out, m_state); end
      n_total++; if (hif.flush_out !== (m_state == 2)) begin n_bad++; $display("FAIL rnd_flush t=%0d: got %b want %b", t, hif.flush_out, m_state == 2); end
      n_total++; if (hif.busy_out !== m_busy()) begin n_bad++; $display("FAIL rnd_busy t=%0d: got %h want %h", t, hif.busy_out, m_busy()); end
      n_total++; if (hif.err_out !== m_err) begin n_bad++; $display("FAIL rnd_err t=%0d: got %b want %b", t, hif.err_out, m_err); end
      $display("rnd t=%0d rst=%b v=%b redir=%b issue=%b stall=%b state=%0d busy=%h err=%b",
               t, rst, hif.dec_valid, hif.redirect, hif.issue_out, hif.stall_out, hif.state_out, hif.busy_out, hif.err_out);
      advance();
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    clear_inputs();
    rst = 1'b1;
    #2;
    test_reset();
    test_raw();
    test_x0();
    test_redirect();
    test_waw();
    test_simul_kill();
    test_reset_mid_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
